alu_exec_unit: RTL and testbench

//  Execute-stage ALU that consumes the 3-bit ALUControl code from the ALU decoder.

---
 rtl/alu_exec_unit.sv | 115 +++++++++++
 tb/tb_alu_exec_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB/SLT and an iterative WIDTH-cycle
// unsigned shift-add MULTU into HI/LO.
module alu_exec_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(1);

   typedef enum logic {IDLE, MUL} state_t;

   state_t             state_q;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic               out_valid_q, zero_q, illegal_q;
   logic [WIDTH-1:0]   result_q, hi_q, lo_q;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_ill;

   always_comb begin
      alu_res = '0;
      alu_ill = 1'b0;
      case (alu_control)
         3'b000:  alu_res = src_a & src_b;
         3'b001:  alu_res = src_a | src_b;
         3'b010:  alu_res = src_a + src_b;
         3'b110:  alu_res = src_a - src_b;
         3'b111:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         3'b100,
         3'b101:  alu_ill = 1'b1;
         default: alu_res = '0;
      endcase
   end

   // Multiplicand shifts left and multiplier shifts right each step, so bit 0 of the
   // multiplier always selects whether the current multiplicand weight is added.
   assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b1;
         illegal_q   <= 1'b0;
         hi_q        <= '0;
         lo_q        <= '0;
      end else begin
         out_valid_q <= 1'b0;
         illegal_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  if (alu_control == 3'b011) begin
                     mcand_q  <= {{WIDTH{1'b0}}, src_a};
                     mplier_q <= src_b;
                     acc_q    <= '0;
                     cnt_q    <= CNT_INIT;
                     state_q  <= MUL;
                  end else begin
                     out_valid_q <= 1'b1;
                     result_q    <= alu_res;
                     zero_q      <= (alu_res == '0);
                     illegal_q   <= alu_ill;
                  end
               end
            end
            MUL: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q - CNT_LAST;
               if (cnt_q == CNT_LAST) begin
                  hi_q        <= acc_d[2*WIDTH-1:WIDTH];
                  lo_q        <= acc_d[WIDTH-1:0];
                  result_q    <= acc_d[WIDTH-1:0];
                  zero_q      <= (acc_d[WIDTH-1:0] == '0);
                  out_valid_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed cases on a 32-bit instance, MULTU and random
// simple ops on both 32-bit and 8-bit instances against an arithmetic reference model.
module tb_alu_exec_unit;

   logic        clk = 1'b0, rst = 1'b1;
   logic        in_v = 1'b0, en32 = 1'b1, en8 = 1'b0, sel = 1'b0;
   logic [2:0]  ctl = 3'b000;
   logic [31:0] a = '0, b = '0;

   logic        rdy32, ov32, z32, il32;
   logic [31:0] res32, hi32, lo32;
   logic        rdy8, ov8, z8, il8;
   logic [7:0]  res8, hi8, lo8;

   logic        m_rdy, m_ov, m_z, m_il;
   logic [31:0] m_res, m_hi, m_lo;

   int n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   alu_exec_unit #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(rst), .in_valid(in_v & en32), .in_ready(rdy32),
      .alu_control(ctl), .src_a(a), .src_b(b),
      .out_valid(ov32), .result(res32), .zero(z32), .illegal(il32), .hi(hi32), .lo(lo32));

   alu_exec_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(rst), .in_valid(in_v & en8), .in_ready(rdy8),
      .alu_control(ctl), .src_a(a[7:0]), .src_b(b[7:0]),
      .out_valid(ov8), .result(res8), .zero(z8), .illegal(il8), .hi(hi8), .lo(lo8));

   assign m_rdy = sel ? rdy8 : rdy32;
   assign m_ov  = sel ? ov8  : ov32;
   assign m_z   = sel ? z8   : z32;
   assign m_il  = sel ? il8  : il32;
   assign m_res = sel ? {24'h0, res8} : res32;
   assign m_hi  = sel ? {24'h0, hi8}  : hi32;
   assign m_lo  = sel ? {24'h0, lo8}  : lo32;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
      in_v = 1'b1; ctl = c; a = x; b = y;
   endtask

   // Reference: plain arithmetic on w-bit unsigned/signed values.
   function automatic logic [31:0] ref_op(input logic [2:0] c, input logic [31:0] x,
                                          input logic [31:0] y, input int w);
      longint m, ux, uy, sx, sy, r;
      m  = (longint'(1) <<< w) - 1;
      ux = longint'(x) & m;
      uy = longint'(y) & m;
      sx = (ux >= (longint'(1) <<< (w-1))) ? ux - (longint'(1) <<< w) : ux;
      sy = (uy >= (longint'(1) <<< (w-1))) ? uy - (longint'(1) <<< w) : uy;
      case (c)
         3'b000:  r = ux & uy;
         3'b001:  r = ux | uy;
         3'b010:  r = (ux + uy) & m;
         3'b110:  r = (ux - uy) & m;
         3'b111:  r = (sx < sy) ? 1 : 0;
         default: r = 0;
      endcase
      return 32'(r);
   endfunction

   // MULTU on the selected instance; an ADD is offered mid-multiply and must be dropped.
   task automatic run_mul(input logic s, input logic [31:0] x, input logic [31:0] y, input int w);
      longint unsigned m, p;
      int lat, low;
      bit done;
      m = (64'd1 << w) - 1;
      p = (64'(x) & m) * (64'(y) & m);
      sel = s;
      @(negedge clk); issue(3'b011, x, y);
      lat = 0; low = 0; done = 0;
      for (int j = 0; j < w + 8 && !done; j++) begin
         @(negedge clk);
         if (m_ov) begin
            done = 1; lat = j;
         end else if (!m_rdy) low++;
         if (j == 2) issue(3'b010, 32'd1, 32'd1);
         else in_v = 1'b0;
      end
      in_v = 1'b0;
      chk("mul_latency", 64'(lat), 64'(w));
      chk("mul_ready_low", 64'(low), 64'(w));
      chk("mul_hi", 64'(m_hi), p >> w);
      chk("mul_lo", 64'(m_lo), p & m);
      chk("mul_result", 64'(m_res), p & m);
      chk("mul_zero", 64'(m_z), 64'((p & m) == 0));
      @(negedge clk);
      chk("mul_ov_drop", 64'(m_ov), 64'd0);
      chk("mul_res_hold", 64'(m_res), p & m);
   endtask

   logic [2:0]  ops [7] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b100, 3'b101};
   logic [31:0] e_res [2];
   logic        e_ov [2], e_z [2], e_il [2];
   int          wd [2] = '{32, 8};
   int          pulses;

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_ov", 64'(ov32), 0);  chk("rst_res", 64'(res32), 0);
      chk("rst_zero", 64'(z32), 1); chk("rst_ill", 64'(il32), 0);
      chk("rst_hi", 64'(hi32), 0);  chk("rst_lo", 64'(lo32), 0);
      chk("rst_rdy", 64'(rdy32), 1);
      rst = 1'b0;

      // ADD, then back-to-back SUB/SLT/AND/OR
      @(negedge clk); issue(3'b010, 32'd5, 32'd7);
      @(negedge clk); in_v = 1'b0;
      chk("add_ov", 64'(ov32), 1); chk("add_res", 64'(res32), 12); chk("add_zero", 64'(z32), 0);
      @(negedge clk); chk("add_ov_drop", 64'(ov32), 0);
      issue(3'b110, 32'd9, 32'd9);
      @(negedge clk); issue(3'b111, 32'hFFFF_FFFF, 32'd1);
      chk("sub_ov", 64'(ov32), 1); chk("sub_res", 64'(res32), 0); chk("sub_zero", 64'(z32), 1);
      @(negedge clk); issue(3'b000, 32'hF0F0, 32'hFF00);
      chk("slt_ov", 64'(ov32), 1); chk("slt_res", 64'(res32), 1); chk("slt_zero", 64'(z32), 0);
      @(negedge clk); issue(3'b001, 32'hF0F0, 32'hFF00);
      chk("and_res", 64'(res32), 64'hF000);
      @(negedge clk); in_v = 1'b0;
      chk("or_res", 64'(res32), 64'hFFF0);
      @(negedge clk); chk("or_ov_drop", 64'(ov32), 0);

      // MULTU on 32-bit instance
      run_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
      run_mul(1'b0, 32'h8000_0001, 32'd6, 32);

      // illegal codes leave hi/lo alone
      @(negedge clk); issue(3'b100, 32'h1234, 32'h5678);
      @(negedge clk); issue(3'b101, 32'hFFFF, 32'h1);
      chk("ill100_ov", 64'(ov32), 1); chk("ill100_flag", 64'(il32), 1);
      chk("ill100_res", 64'(res32), 0); chk("ill100_zero", 64'(z32), 1);
      chk("ill100_hi", 64'(hi32), 3); chk("ill100_lo", 64'(lo32), 6);
      @(negedge clk); in_v = 1'b0;
      chk("ill101_ov", 64'(ov32), 1); chk("ill101_flag", 64'(il32), 1);
      chk("ill101_hi", 64'(hi32), 3); chk("ill101_lo", 64'(lo32), 6);
      @(negedge clk); chk("ill_drop", 64'(il32), 0); chk("ill_ov_drop", 64'(ov32), 0);

      // reset on the 10th MUL cycle aborts the multiply
      @(negedge clk); issue(3'b011, 32'd3, 32'd4);
      for (int j = 0; j < 10; j++) begin
         @(negedge clk); in_v = 1'b0;
      end
      rst = 1'b1; #1;
      chk("abort_rdy", 64'(rdy32), 1); chk("abort_ov", 64'(ov32), 0);
      chk("abort_hi", 64'(hi32), 0);  chk("abort_lo", 64'(lo32), 0);
      chk("abort_res", 64'(res32), 0); chk("abort_zero", 64'(z32), 1);
      @(negedge clk); rst = 1'b0;
      pulses = 0;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk); if (ov32) pulses++;
      end
      chk("abort_no_pulse", 64'(pulses), 0);
      issue(3'b010, 32'd1, 32'd1);
      @(negedge clk); in_v = 1'b0;
      chk("post_abort_add", 64'(res32), 2); chk("post_abort_ov", 64'(ov32), 1);

      // MULTU on 8-bit instance
      en32 = 1'b0; en8 = 1'b1;
      run_mul(1'b1, 32'hFF, 32'hFF, 8);
      for (int i = 0; i < 4; i++) run_mul(1'b1, 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)), 8);

      // random simple ops, both instances in lockstep, 1 op/cycle
      en32 = 1'b1; en8 = 1'b1;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         e_ov[k] = 1'b0; e_res[k] = '0; e_z[k] = 1'b1; e_il[k] = 1'b0;
      end
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            sel = k[0]; #1;
            chk("rnd_ov", 64'(m_ov), 64'(e_ov[k]));
            chk("rnd_res", 64'(m_res), 64'(e_res[k]));
            chk("rnd_zero", 64'(m_z), 64'(e_z[k]));
            chk("rnd_ill", 64'(m_il), 64'(e_il[k]));
            chk("rnd_hi", 64'(m_hi), 0);
            chk("rnd_lo", 64'(m_lo), 0);
         end
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         ctl = ops[$urandom_range(0, 6)];
         in_v = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < 2; k++) begin
            e_ov[k] = in_v;
            e_il[k] = in_v && (ctl == 3'b100 || ctl == 3'b101);
            if (in_v) begin
               e_res[k] = ref_op(ctl, a, b, wd[k]);
               e_z[k]   = (e_res[k] == 0);
            end
         end
      end
      in_v = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
